// File: rtl/dwt_pkg.sv
// Shared constants, FSM encoding and arithmetic helpers for the inverse 2-D Haar path.
package dwt_pkg;

  localparam int unsigned N      = 8;
  localparam int unsigned PIX_W  = 8;
  localparam int unsigned COEF_W = 10;
  localparam int unsigned IW     = COEF_W + 2;

  localparam logic signed [IW-1:0] ONE_S   = IW'(1);
  localparam logic signed [IW-1:0] PIX_MAX = IW'((1 << PIX_W) - 1);

  typedef enum logic [1:0] {IDLE, COL, ROW, DONE} state_t;

  // One inverse S-transform lifting step; returns {a, b}.
  function automatic logic [2*IW-1:0] haar_inv(input logic signed [IW-1:0] s,
                                               input logic signed [IW-1:0] d);
    logic signed [IW-1:0] r;
    logic signed [IW-1:0] a;
    logic signed [IW-1:0] b;
    r = d + ONE_S;
    a = s + (r >>> 1);
    b = a - d;
    return {a, b};
  endfunction

  // Saturate to the unsigned pixel range; returns {pixel, clipped}.
  function automatic logic [PIX_W:0] clip_pix(input logic signed [IW-1:0] v);
    if (v[IW-1]) return {PIX_W'(0), 1'b1};
    if (v > PIX_MAX) return {PIX_W'(PIX_MAX), 1'b1};
    return {v[PIX_W-1:0], 1'b0};
  endfunction

endpackage

// File: rtl/haar_inv_lift.sv
// Combinational inverse lifting step shared by the column and row passes.
module haar_inv_lift
  import dwt_pkg::*;
(
  input  logic signed [IW-1:0] s,
  input  logic signed [IW-1:0] d,
  output logic signed [IW-1:0] a,
  output logic signed [IW-1:0] b
);

  assign {a, b} = haar_inv(s, d);

endmodule

// File: rtl/wavelet_2d_inv.sv
// Inverse 2-D integer Haar for a 2xN block: column pass, then row pass, then clip.
module wavelet_2d_inv
  import dwt_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*COEF_W-1:0]     coef_row0,
  input  logic [N*COEF_W-1:0]     coef_row1,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N*PIX_W-1:0]      pixel_row0,
  output logic [N*PIX_W-1:0]      pixel_row1,
  output logic                    out_clip,
  output logic                    busy
);

  localparam int unsigned HALF = N / 2;
  localparam int unsigned CW   = $clog2(HALF);
  localparam int unsigned XW   = $clog2(N);

  state_t               state;
  logic [CW-1:0]        cnt;
  logic signed [IW-1:0] mid [2][N];
  logic [PIX_W-1:0]     pix [2][N];

  logic [XW-1:0]        ie, io, lo, hi;
  logic signed [IW-1:0] s0, d0, s1, d1, a0, b0, a1, b1;
  logic [PIX_W:0]       c0a, c0b, c1a, c1b;
  logic                 accept, last;

  assign in_ready = (state == IDLE) || (state == DONE && out_ready);
  assign accept   = in_valid && in_ready;
  assign last     = (cnt == CW'(HALF - 1));

  // COL feeds columns 2cnt/2cnt+1; ROW feeds pair cnt of row0 and row1.
  always_comb begin
    ie = {cnt, 1'b0};
    io = {cnt, 1'b1};
    lo = {1'b0, cnt};
    hi = {1'b1, cnt};
    if (state == ROW) begin
      s0 = mid[0][lo];
      d0 = mid[0][hi];
      s1 = mid[1][lo];
      d1 = mid[1][hi];
    end else begin
      s0 = mid[0][ie];
      d0 = mid[1][ie];
      s1 = mid[0][io];
      d1 = mid[1][io];
    end
  end

  haar_inv_lift u_lift0 (.s(s0), .d(d0), .a(a0), .b(b0));
  haar_inv_lift u_lift1 (.s(s1), .d(d1), .a(a1), .b(b1));

  assign c0a = clip_pix(a0);
  assign c0b = clip_pix(b0);
  assign c1a = clip_pix(a1);
  assign c1b = clip_pix(b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_clip  <= 1'b0;
      busy      <= 1'b0;
      for (int r = 0; r < 2; r++) begin
        for (int j = 0; j < N; j++) begin
          mid[r][j] <= '0;
          pix[r][j] <= '0;
        end
      end
    end else if (accept) begin
      for (int j = 0; j < N; j++) begin
        mid[0][j] <= IW'($signed(coef_row0[(N-1-j)*COEF_W +: COEF_W]));
        mid[1][j] <= IW'($signed(coef_row1[(N-1-j)*COEF_W +: COEF_W]));
      end
      state     <= COL;
      cnt       <= '0;
      busy      <= 1'b1;
      out_valid <= 1'b0;
      out_clip  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: ;
        COL: begin
          mid[0][ie] <= a0;
          mid[1][ie] <= b0;
          mid[0][io] <= a1;
          mid[1][io] <= b1;
          cnt        <= last ? '0 : cnt + 1'b1;
          if (last) state <= ROW;
        end
        ROW: begin
          pix[0][ie] <= c0a[PIX_W:1];
          pix[0][io] <= c0b[PIX_W:1];
          pix[1][ie] <= c1a[PIX_W:1];
          pix[1][io] <= c1b[PIX_W:1];
          out_clip   <= out_clip | c0a[0] | c0b[0] | c1a[0] | c1b[0];
          cnt        <= last ? '0 : cnt + 1'b1;
          if (last) begin
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
      endcase
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign pixel_row0[(N-1-g)*PIX_W +: PIX_W] = pix[0][g];
    assign pixel_row1[(N-1-g)*PIX_W +: PIX_W] = pix[1][g];
  end

endmodule

// File: tb/tb_wavelet_2d_inv.sv
// Bench for wavelet_2d_inv: arithmetic reference model, per-cycle compare, directed vectors.
module tb_wavelet_2d_inv;
  import dwt_pkg::*;

  localparam int unsigned CV = N * COEF_W;
  localparam int unsigned PV = N * PIX_W;

  typedef struct packed {
    logic [PV-1:0] p0;
    logic [PV-1:0] p1;
    logic          clip;
  } blk_t;

  logic          clk, rst_n, in_valid, in_ready, out_valid, out_ready, out_clip, busy;
  logic [CV-1:0] coef_row0, coef_row1;
  logic [PV-1:0] pixel_row0, pixel_row1;

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  blk_t exp_q[$];
  int   acc_q[$];
  bit   shown  = 0;

  wavelet_2d_inv dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .coef_row0(coef_row0), .coef_row1(coef_row1), .out_valid(out_valid),
    .out_ready(out_ready), .pixel_row0(pixel_row0), .pixel_row1(pixel_row1),
    .out_clip(out_clip), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [CV-1:0] act, input logic [CV-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // floor(x/2) for any sign
  function automatic int fdiv2(input int x);
    return (x >= 0) ? x / 2 : -((1 - x) / 2);
  endfunction

  function automatic logic [PIX_W-1:0] clampv(input int v, inout logic c);
    if (v < 0) begin c = 1'b1; return '0; end
    if (v > 255) begin c = 1'b1; return 8'hFF; end
    return PIX_W'(v);
  endfunction

  function automatic blk_t inv_model(input logic [CV-1:0] c0, input logic [CV-1:0] c1);
    int   r [2][N];
    int   s, d, a;
    blk_t o;
    logic c;
    o = '0;
    c = 1'b0;
    for (int j = 0; j < N; j++) begin
      r[0][j] = $signed(c0[(N-1-j)*COEF_W +: COEF_W]);
      r[1][j] = $signed(c1[(N-1-j)*COEF_W +: COEF_W]);
    end
    for (int j = 0; j < N; j++) begin
      s = r[0][j]; d = r[1][j];
      a = s + fdiv2(d + 1);
      r[0][j] = a;
      r[1][j] = a - d;
    end
    for (int k = 0; k < N / 2; k++) begin
      s = r[0][k]; d = r[0][N/2+k]; a = s + fdiv2(d + 1);
      o.p0[(N-1-2*k)*PIX_W +: PIX_W] = clampv(a, c);
      o.p0[(N-2-2*k)*PIX_W +: PIX_W] = clampv(a - d, c);
      s = r[1][k]; d = r[1][N/2+k]; a = s + fdiv2(d + 1);
      o.p1[(N-1-2*k)*PIX_W +: PIX_W] = clampv(a, c);
      o.p1[(N-2-2*k)*PIX_W +: PIX_W] = clampv(a - d, c);
    end
    o.clip = c;
    return o;
  endfunction

  // Forward S-transform: row pass then column pass.
  task automatic fwd(input logic [PV-1:0] p0, input logic [PV-1:0] p1,
                     output logic [CV-1:0] c0, output logic [CV-1:0] c1);
    int r [2][N];
    int a, b, d;
    for (int k = 0; k < N / 2; k++) begin
      a = p0[(N-1-2*k)*PIX_W +: PIX_W]; b = p0[(N-2-2*k)*PIX_W +: PIX_W];
      d = a - b; r[0][k] = b + fdiv2(d); r[0][N/2+k] = d;
      a = p1[(N-1-2*k)*PIX_W +: PIX_W]; b = p1[(N-2-2*k)*PIX_W +: PIX_W];
      d = a - b; r[1][k] = b + fdiv2(d); r[1][N/2+k] = d;
    end
    c0 = '0;
    c1 = '0;
    for (int j = 0; j < N; j++) begin
      d = r[0][j] - r[1][j];
      c0[(N-1-j)*COEF_W +: COEF_W] = COEF_W'(r[1][j] + fdiv2(d));
      c1[(N-1-j)*COEF_W +: COEF_W] = COEF_W'(d);
    end
  endtask

  // Compare process: handshake flags, latency and payload against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      acc_q.delete();
      shown = 0;
    end else begin
      check("in_ready", CV'(in_ready), CV'((exp_q.size() == 0) || (out_valid && out_ready)));
      check("busy", CV'(busy), CV'((exp_q.size() != 0) && !out_valid));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", CV'(out_valid), CV'(0));
        end else begin
          if (!shown) begin
            check("latency", CV'(cyc - acc_q[0]), CV'(N));
            shown = 1;
          end
          check("model_row0", CV'(pixel_row0), CV'(exp_q[0].p0));
          check("model_row1", CV'(pixel_row1), CV'(exp_q[0].p1));
          check("model_clip", CV'(out_clip), CV'(exp_q[0].clip));
          if (out_ready) begin
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
            shown = 0;
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(inv_model(coef_row0, coef_row1));
        acc_q.push_back(cyc + 1);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic send(input logic [CV-1:0] c0, input logic [CV-1:0] c1);
    bit got = 0;
    in_valid  = 1'b1;
    coef_row0 = c0;
    coef_row1 = c1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
    end
    if (!got) check("accept_timeout", CV'(0), CV'(1));
    in_valid  = 1'b0;
    coef_row0 = CV'({$urandom(), $urandom(), $urandom()});
    coef_row1 = CV'({$urandom(), $urandom(), $urandom()});
  endtask

  // Returns at the negedge where out_valid is first seen high.
  task automatic wait_valid(input string name);
    bit got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = out_valid;
    end
    if (!got) check({name, "_valid_timeout"}, CV'(0), CV'(1));
  endtask

  task automatic consume();
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_block(input string name, input logic [CV-1:0] c0, input logic [CV-1:0] c1,
                           input logic [PV-1:0] e0, input logic [PV-1:0] e1, input logic eclip);
    send(c0, c1);
    wait_valid(name);
    check({name, "_row0"}, CV'(pixel_row0), CV'(e0));
    check({name, "_row1"}, CV'(pixel_row1), CV'(e1));
    check({name, "_clip"}, CV'(out_clip), CV'(eclip));
    consume();
  endtask

  logic [CV-1:0] t1_c0, t2_c0, t3_c0, t3_c1, t4_c0, t4_c1, zc, rc0, rc1;
  logic [PV-1:0] rt [4];
  bit            stale;

  initial begin
    t1_c0 = {{4{10'd100}}, {4{10'd0}}};
    t2_c0 = {{4{10'd10}}, 10'd1, {3{10'd0}}};
    t3_c0 = {{4{10'd50}}, {4{10'd0}}};
    t3_c1 = {10'h3FD, {7{10'd0}}};
    t4_c0 = {10'd255, {7{10'd0}}};
    t4_c1 = {10'd514, {7{10'd0}}};
    zc    = '0;
    rt[0] = 64'h403E3D454749494A;
    rt[1] = 64'h3C373A3B3E404A4C;
    rt[2] = rt[1];
    rt[3] = rt[0];

    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; coef_row0 = '0; coef_row1 = '0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid", CV'(out_valid), CV'(0));
    check("rst_row0", CV'(pixel_row0), CV'(0));
    check("rst_row1", CV'(pixel_row1), CV'(0));
    check("rst_clip", CV'(out_clip), CV'(0));
    check("rst_busy", CV'(busy), CV'(0));
    check("rst_in_ready", CV'(in_ready), CV'(1));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_block("t1", t1_c0, zc, {8{8'h64}}, {8{8'h64}}, 1'b0);
    run_block("t2", t2_c0, zc, 64'h0B0A0A0A0A0A0A0A, 64'h0B0A0A0A0A0A0A0A, 1'b0);
    run_block("t3", t3_c0, t3_c1, 64'h3131323232323232, 64'h3434323232323232, 1'b0);
    run_block("t4", t4_c0, t4_c1, 64'h0, 64'hFFFF000000000000, 1'b1);

    // Backpressure with a second block waiting on in_valid.
    send(t1_c0, zc);
    in_valid = 1'b1; coef_row0 = t2_c0; coef_row1 = zc;
    wait_valid("t5");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("t5_hold_ready", CV'(in_ready), CV'(0));
      check("t5_hold_valid", CV'(out_valid), CV'(1));
      check("t5_hold_row0", CV'(pixel_row0), CV'({8{8'h64}}));
      check("t5_hold_row1", CV'(pixel_row1), CV'({8{8'h64}}));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("t5_busy_after", CV'(busy), CV'(1));
    check("t5_valid_after", CV'(out_valid), CV'(0));
    wait_valid("t5b");
    check("t5b_row0", CV'(pixel_row0), CV'(64'h0B0A0A0A0A0A0A0A));
    consume();

    // Reset while in the row pass.
    send(t3_c0, t3_c1);
    repeat (5) @(posedge clk);
    #2;
    check("t6_busy_pre", CV'(busy), CV'(1));
    rst_n = 1'b0;
    #1;
    check("t6_valid", CV'(out_valid), CV'(0));
    check("t6_ready", CV'(in_ready), CV'(1));
    check("t6_busy", CV'(busy), CV'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) stale = 1;
    end
    check("t6_no_stale", CV'(stale), CV'(0));
    @(posedge clk); #1;
    run_block("t6_t1", t1_c0, zc, {8{8'h64}}, {8{8'h64}}, 1'b0);

    // Round trip through the forward transform.
    for (int i = 0; i < 4; i += 2) begin
      fwd(rt[i], rt[i+1], rc0, rc1);
      run_block($sformatf("rt%0d", i / 2), rc0, rc1, rt[i], rt[i+1], 1'b0);
    end

    repeat (3) @(posedge clk);
    check("drain", CV'(exp_q.size()), CV'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1, "watchdog");
  end

endmodule
